binary_to_bcd: RTL

BINARY_TO_BCD -- requirements
Module: binary_to_bcd

---
 rtl/binary_to_bcd.sv | 124 ++++++++++++
 1 files changed

// File: rtl/binary_to_bcd.sv
// binary_to_bcd: serial double-dabble converter from an unsigned binary
// operand to three packed BCD digits. One bit is shifted per clock; operands
// above 999 are flagged as overflow without shifting.
module binary_to_bcd #(
  parameter int BIN_WIDTH = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] binaryIn,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [11:0]          bcdOut
);

  localparam int CW = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [11:0]          scratch_reg;
  logic [CW-1:0]        count_reg;
  logic [11:0]          scratch_adj;
  logic [11:0]          scratch_shifted;
  logic                 too_big;
  logic                 last_shift;

  // Operands wider than three decimal digits cannot be represented.
  assign too_big    = 32'(binaryIn) > 32'd999;
  assign last_shift = (count_reg == CW'(1));

  // Add 3 to every digit that is 5 or more so the following shift carries
  // correctly into the next decimal digit.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                      ? scratch_reg[gi*4 +: 4] + 4'd3
                                      : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  // The next binary bit enters the units digit from the operand MSB.
  assign scratch_shifted = {scratch_adj[10:0], shift_reg[BIN_WIDTH-1]};

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = too_big ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Conversion datapath and held result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      scratch_reg <= '0;
      count_reg   <= '0;
      bcdOut      <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg   <= binaryIn;
            scratch_reg <= '0;
            count_reg   <= CW'(BIN_WIDTH);
            if (too_big) begin
              bcdOut   <= '0;
              overflow <= 1'b1;
            end
          end
        end
        SHIFT: begin
          scratch_reg <= scratch_shifted;
          shift_reg   <= shift_reg << 1;
          count_reg   <= count_reg - CW'(1);
          if (last_shift) begin
            bcdOut   <= scratch_shifted;
            overflow <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);

endmodule
